// File: rtl/even_pipe_issue_ctrl_pkg.sv
// Shared types and sizing for the SPU even-pipe issue controller: slot layout
// {valid, reg_dst, reg_wr} and the pipe geometry.
package even_pipe_issue_ctrl_pkg;

  localparam int MAX_LAT = 7;
  localparam int REG_AW  = 7;
  localparam int LAT_W   = 4;
  localparam int CNT_W   = 16;

  // Slots 2..MAX_LAT are the ones that can produce a register hazard.
  localparam int HAZ_N   = MAX_LAT - 1;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] reg_dst;
    logic              reg_wr;
  } slot_t;

  typedef slot_t [MAX_LAT:1] slot_vec_t;

  function automatic logic [LAT_W-1:0] count_valid(input slot_vec_t s);
    logic [LAT_W-1:0] cnt;
    cnt = '0;
    for (int k = 1; k <= MAX_LAT; k++) begin
      cnt = cnt + {{(LAT_W-1){1'b0}}, s[k].valid};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/spu_hazard_cmp.sv
// Compares one register address against the writing slots 2..MAX_LAT and
// flags a hit; used for each RAW source port and for the WAW destination.
module spu_hazard_cmp
  import even_pipe_issue_ctrl_pkg::*;
(
  input  logic [REG_AW-1:0]       addr,
  input  logic                    en,
  input  logic [HAZ_N-1:0]        cand_valid,
  input  logic [HAZ_N*REG_AW-1:0] cand_dst,
  output logic                    hit
);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < HAZ_N; i++) begin
      hit = hit | (en & cand_valid[i] & (cand_dst[i*REG_AW +: REG_AW] == addr));
    end
  end

endmodule

// File: rtl/even_pipe_issue_ctrl.sv
// Even-pipe issue scheduler: reserves a writeback slot per accepted instruction
// in a latency-indexed shift register and stalls on WB-port, RAW and WAW hazards.
module even_pipe_issue_ctrl
  import even_pipe_issue_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_reg_dst,
  input  logic              issue_reg_wr,
  input  logic [LAT_W-1:0]  issue_latency,
  input  logic [REG_AW-1:0] src_ra,
  input  logic [REG_AW-1:0] src_rb,
  input  logic [REG_AW-1:0] src_rc,
  input  logic [2:0]        src_used,
  output logic              issue_ready,
  output logic              issue_fire,
  output logic              illegal_lat,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_reg_addr,
  output logic              wb_reg_wr,
  output logic [LAT_W-1:0]  occupancy,
  output logic [CNT_W-1:0]  stall_count
);

  slot_vec_t               slots;
  slot_vec_t               slots_next;
  logic [HAZ_N-1:0]        cand_valid;
  logic [HAZ_N*REG_AW-1:0] cand_dst;
  logic [REG_AW-1:0]       src_addr [3];
  logic [2:0]              raw_hit;
  logic                    waw_hit;
  logic                    wb_conflict;

  // slot[1] is left out of the hazard view: the RF bypasses its write to readers.
  always_comb begin
    cand_valid = '0;
    cand_dst   = '0;
    for (int k = 2; k <= MAX_LAT; k++) begin
      cand_valid[k-2]                    = slots[k].valid & slots[k].reg_wr;
      cand_dst[(k-2)*REG_AW +: REG_AW]   = slots[k].reg_dst;
    end
  end

  assign src_addr[0] = src_ra;
  assign src_addr[1] = src_rb;
  assign src_addr[2] = src_rc;

  for (genvar p = 0; p < 3; p++) begin : g_raw
    spu_hazard_cmp u_raw_cmp (
      .addr       (src_addr[p]),
      .en         (src_used[p]),
      .cand_valid (cand_valid),
      .cand_dst   (cand_dst),
      .hit        (raw_hit[p])
    );
  end

  spu_hazard_cmp u_waw_cmp (
    .addr       (issue_reg_dst),
    .en         (issue_reg_wr),
    .cand_valid (cand_valid),
    .cand_dst   (cand_dst),
    .hit        (waw_hit)
  );

  // An entry in slot[L+1] lands in slot[L] next cycle, exactly where we would write.
  always_comb begin
    wb_conflict = 1'b0;
    for (int k = 1; k < MAX_LAT; k++) begin
      if (issue_latency == LAT_W'(k) && slots[k+1].valid) wb_conflict = 1'b1;
    end
  end

  assign illegal_lat = issue_valid &
                       ((issue_latency == '0) || (issue_latency > LAT_W'(MAX_LAT)));
  assign issue_ready = ~flush & ~illegal_lat & ~wb_conflict & ~(|raw_hit) & ~waw_hit;
  assign issue_fire  = issue_valid & issue_ready;

  always_comb begin
    slots_next = '0;
    if (!flush) begin
      for (int k = 1; k < MAX_LAT; k++) slots_next[k] = slots[k+1];
      for (int k = 1; k <= MAX_LAT; k++) begin
        if (issue_fire && issue_latency == LAT_W'(k)) begin
          slots_next[k].valid   = 1'b1;
          slots_next[k].reg_dst = issue_reg_dst;
          slots_next[k].reg_wr  = issue_reg_wr;
        end
      end
    end
  end

  // NOTE: the slot array is small control state that must read invalid right
  // after reset, so it is reset like any flop rather than treated as a RAM.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slots       <= '0;
      occupancy   <= '0;
      stall_count <= '0;
    end else begin
      slots     <= slots_next;
      occupancy <= count_valid(slots_next);
      if (issue_valid && !issue_ready && stall_count != '1) begin
        stall_count <= stall_count + CNT_W'(1);
      end
    end
  end

  assign wb_valid    = slots[1].valid;
  assign wb_reg_addr = slots[1].reg_dst;
  assign wb_reg_wr   = slots[1].valid & slots[1].reg_wr;

endmodule

// File: tb/tb_even_pipe_issue_ctrl.sv
// Directed bench for even_pipe_issue_ctrl: latency timing, WB/RAW/WAW stalls,
// illegal latency, flush and async reset, against hand-computed expectations.
module tb_even_pipe_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       issue_valid;
  logic [6:0] issue_reg_dst;
  logic       issue_reg_wr;
  logic [3:0] issue_latency;
  logic [6:0] src_ra, src_rb, src_rc;
  logic [2:0] src_used;
  logic       issue_ready, issue_fire, illegal_lat;
  logic       wb_valid;
  logic [6:0] wb_reg_addr;
  logic       wb_reg_wr;
  logic [3:0] occupancy;
  logic [15:0] stall_count;

  int checks = 0;
  int errors = 0;
  int exp_stall = 0;

  even_pipe_issue_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .issue_valid   (issue_valid),
    .issue_reg_dst (issue_reg_dst),
    .issue_reg_wr  (issue_reg_wr),
    .issue_latency (issue_latency),
    .src_ra        (src_ra),
    .src_rb        (src_rb),
    .src_rc        (src_rc),
    .src_used      (src_used),
    .issue_ready   (issue_ready),
    .issue_fire    (issue_fire),
    .illegal_lat   (illegal_lat),
    .wb_valid      (wb_valid),
    .wb_reg_addr   (wb_reg_addr),
    .wb_reg_wr     (wb_reg_wr),
    .occupancy     (occupancy),
    .stall_count   (stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [6:0] dst, input logic wr,
                       input logic [3:0] lat, input logic [6:0] ra, input logic [6:0] rb,
                       input logic [6:0] rc, input logic [2:0] used);
    issue_valid   = v;
    issue_reg_dst = dst;
    issue_reg_wr  = wr;
    issue_latency = lat;
    src_ra        = ra;
    src_rb        = rb;
    src_rc        = rc;
    src_used      = used;
  endtask

  task automatic idle();
    drive(1'b0, 7'h0, 1'b0, 4'd1, 7'h0, 7'h0, 7'h0, 3'b000);
  endtask

  // Returns 1 ns after the next rising edge, leaving inputs unchanged.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    idle();
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    idle();
    #2;
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_wr", 32'(wb_reg_wr), 32'd0);
    check("rst_wb_addr", 32'(wb_reg_addr), 32'd0);
    check("rst_occ", 32'(occupancy), 32'd0);
    check("rst_stall", 32'(stall_count), 32'd0);
    step();
    rst = 1'b0;
    step();

    // Idle: any legal instruction is ready; pulled back before the edge.
    for (int l = 1; l <= 7; l++) begin
      drive(1'b1, 7'h3, 1'b1, 4'(l), 7'h1, 7'h2, 7'h4, 3'b111);
      #1;
      check("idle_ready", 32'(issue_ready), 32'd1);
      idle();
    end
    step();
    #1;
    check("idle_occ", 32'(occupancy), 32'd0);

    // Latency 2: WB exactly two cycles after fire.
    drive(1'b1, 7'd7, 1'b1, 4'd2, 7'h0, 7'h0, 7'h0, 3'b000);
    #1;
    check("lat2_fire", 32'(issue_fire), 32'd1);
    step();
    idle();
    #1;
    check("lat2_wb_t1", 32'(wb_valid), 32'd0);
    check("lat2_occ_t1", 32'(occupancy), 32'd1);
    step();
    #1;
    check("lat2_wb_t2", 32'(wb_valid), 32'd1);
    check("lat2_addr_t2", 32'(wb_reg_addr), 32'd7);
    check("lat2_wr_t2", 32'(wb_reg_wr), 32'd1);
    step();
    #1;
    check("lat2_wb_t3", 32'(wb_valid), 32'd0);
    drain(8);

    // WB port collision: L=5 then L=4 next cycle.
    drive(1'b1, 7'd10, 1'b1, 4'd5, 7'h0, 7'h0, 7'h0, 3'b000);
    #1;
    check("wbc_fire_a", 32'(issue_fire), 32'd1);
    step();
    drive(1'b1, 7'd11, 1'b1, 4'd4, 7'h0, 7'h0, 7'h0, 3'b000);
    #1;
    check("wbc_stall", 32'(issue_ready), 32'd0);
    exp_stall++;
    step();
    #1;
    check("wbc_retry", 32'(issue_fire), 32'd1);
    step();
    idle();
    #1;
    check("wbc_stall_cnt", 32'(stall_count), 32'(exp_stall));
    check("wbc_occ", 32'(occupancy), 32'd2);
    drain(8);

    // RAW on ra against an L=6 producer: blocked while it sits in slots 6..2.
    drive(1'b1, 7'h71, 1'b1, 4'd6, 7'h0, 7'h0, 7'h0, 3'b000);
    #1;
    check("raw_prod_fire", 32'(issue_fire), 32'd1);
    step();
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 7'h05, 1'b1, 4'd7, 7'h71, 7'h0, 7'h0, 3'b001);
      #1;
      check("raw_stall", 32'(issue_ready), 32'd0);
      exp_stall++;
      step();
    end
    #1;
    check("raw_prod_wb", 32'(wb_valid), 32'd1);
    check("raw_accept", 32'(issue_fire), 32'd1);
    drain(8);
    #1;
    check("raw_stall_cnt", 32'(stall_count), 32'(exp_stall));

    // WAW on the same destination.
    drive(1'b1, 7'h71, 1'b1, 4'd6, 7'h0, 7'h0, 7'h0, 3'b000);
    #1;
    check("waw_prod_fire", 32'(issue_fire), 32'd1);
    step();
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 7'h71, 1'b1, 4'd7, 7'h0, 7'h0, 7'h0, 3'b000);
      #1;
      check("waw_stall", 32'(issue_ready), 32'd0);
      exp_stall++;
      step();
    end
    #1;
    check("waw_accept", 32'(issue_fire), 32'd1);
    drain(8);

    // A non-writing entry creates no register hazard on any port.
    drive(1'b1, 7'h22, 1'b0, 4'd6, 7'h0, 7'h0, 7'h0, 3'b000);
    #1;
    check("nowr_fire", 32'(issue_fire), 32'd1);
    step();
    drive(1'b1, 7'h22, 1'b1, 4'd7, 7'h22, 7'h22, 7'h22, 3'b111);
    #1;
    check("nowr_no_hazard", 32'(issue_ready), 32'd1);
    drain(8);

    // Illegal latencies.
    drive(1'b1, 7'h3, 1'b1, 4'd0, 7'h0, 7'h0, 7'h0, 3'b000);
    #1;
    check("lat0_illegal", 32'(illegal_lat), 32'd1);
    check("lat0_ready", 32'(issue_ready), 32'd0);
    exp_stall++;
    step();
    drive(1'b1, 7'h3, 1'b1, 4'd8, 7'h0, 7'h0, 7'h0, 3'b000);
    #1;
    check("lat8_illegal", 32'(illegal_lat), 32'd1);
    check("lat8_ready", 32'(issue_ready), 32'd0);
    exp_stall++;
    step();
    idle();
    #1;
    check("illegal_occ", 32'(occupancy), 32'd0);
    check("illegal_stall_cnt", 32'(stall_count), 32'(exp_stall));

    // Flush with three in flight and a simultaneous issue.
    drive(1'b1, 7'd1, 1'b1, 4'd3, 7'h0, 7'h0, 7'h0, 3'b000);
    #1;
    check("fl_fire1", 32'(issue_fire), 32'd1);
    step();
    drive(1'b1, 7'd2, 1'b1, 4'd5, 7'h0, 7'h0, 7'h0, 3'b000);
    #1;
    check("fl_fire2", 32'(issue_fire), 32'd1);
    step();
    drive(1'b1, 7'd3, 1'b1, 4'd7, 7'h0, 7'h0, 7'h0, 3'b000);
    #1;
    check("fl_fire3", 32'(issue_fire), 32'd1);
    step();
    drive(1'b1, 7'd4, 1'b1, 4'd6, 7'h0, 7'h0, 7'h0, 3'b000);
    flush = 1'b1;
    #1;
    check("fl_occ_before", 32'(occupancy), 32'd3);
    check("fl_wb_current", 32'(wb_valid), 32'd1);
    check("fl_wb_addr", 32'(wb_reg_addr), 32'd1);
    check("fl_ready", 32'(issue_ready), 32'd0);
    check("fl_no_fire", 32'(issue_fire), 32'd0);
    exp_stall++;
    step();
    flush = 1'b0;
    idle();
    #1;
    check("fl_occ_after", 32'(occupancy), 32'd0);
    for (int i = 0; i < 7; i++) begin
      check("fl_no_wb", 32'(wb_valid), 32'd0);
      step();
    end
    check("fl_stall_cnt", 32'(stall_count), 32'(exp_stall));

    // Asynchronous reset mid-flight.
    drive(1'b1, 7'h15, 1'b1, 4'd2, 7'h0, 7'h0, 7'h0, 3'b000);
    step();
    idle();
    step();
    #1;
    check("arst_wb_before", 32'(wb_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_wb_now", 32'(wb_valid), 32'd0);
    check("arst_occ_now", 32'(occupancy), 32'd0);
    check("arst_stall_now", 32'(stall_count), 32'd0);
    step();
    rst = 1'b0;
    drive(1'b1, 7'h15, 1'b1, 4'd3, 7'h15, 7'h0, 7'h0, 3'b001);
    #1;
    check("arst_ready_after", 32'(issue_ready), 32'd1);
    idle();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
